// File: rtl/vga_timing.sv
// vga_timing: VGA raster timing generator.
//
// Free-running pixel and line counters produce the raster position and the
// sync, blanking and start-of-line/frame flags. All flags are registered
// alongside the counters. They decode the counter values loaded on the same
// edge, so a flag never lags its position by a cycle.
//
// Ports
//   clk_25          in   pixel clock; all state updates on its rising edge
//   rst             in   synchronous, active-high reset
//   horizontal_num  out  [9:0] pixel column, 0..HTOTAL-1
//   vertical_num    out  [9:0] line, 0..VTOTAL-1
//   hsync           out  horizontal sync, active-low
//   vsync           out  vertical sync, active-low (whole line)
//   video_on        out  high inside the visible region
//   frame_start     out  one-cycle pulse at pixel (0,0)
//   line_start      out  one-cycle pulse at pixel column 0
module vga_timing #(
  parameter int HVID  = 640,
  parameter int HFP   = 16,
  parameter int HSYNC = 96,
  parameter int HBP   = 48,
  parameter int VVID  = 480,
  parameter int VFP   = 10,
  parameter int VSYNC = 2,
  parameter int VBP   = 33
) (
  input  logic       clk_25,
  input  logic       rst,
  output logic [9:0] horizontal_num,
  output logic [9:0] vertical_num,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic       line_start
);

  localparam int HTOTAL = HVID + HFP + HSYNC + HBP;
  localparam int VTOTAL = VVID + VFP + VSYNC + VBP;

  // Both counters are 10 bits wide, so neither total may exceed 1024.
  if (HTOTAL > 1024 || VTOTAL > 1024) begin : g_total_too_large
    $error("vga_timing: HTOTAL/VTOTAL must not exceed 1024");
  end

  localparam logic [9:0] H_MAX      = 10'(HTOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(VTOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(HVID);
  localparam logic [9:0] V_VIS      = 10'(VVID);
  localparam logic [9:0] HS_START   = 10'(HVID + HFP);
  localparam logic [9:0] HS_END     = 10'(HVID + HFP + HSYNC - 1);
  localparam logic [9:0] VS_START   = 10'(VVID + VFP);
  localparam logic [9:0] VS_END     = 10'(VVID + VFP + VSYNC - 1);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;
  logic       line_start_q, line_start_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_MAX) begin
      h_d = '0;
      if (v_q == V_MAX) begin
        v_d = '0;
      end else begin
        v_d = v_q + 10'd1;
      end
    end

    // Flags decode the next counter values so they register on the same
    // edge as the counters themselves.
    hsync_d       = !((h_d >= HS_START) && (h_d <= HS_END));
    vsync_d       = !((v_d >= VS_START) && (v_d <= VS_END));
    video_on_d    = (h_d < H_VIS) && (v_d < V_VIS);
    frame_start_d = (h_d == '0) && (v_d == '0);
    line_start_d  = (h_d == '0);
  end

  // Reset parks the counters on the last pixel of the frame, so the first
  // edge after release lands on (0,0).
  always_ff @(posedge clk_25) begin
    if (rst) begin
      h_q           <= H_MAX;
      v_q           <= V_MAX;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
    end
  end

  assign horizontal_num = h_q;
  assign vertical_num   = v_q;
  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign video_on       = video_on_q;
  assign frame_start    = frame_start_q;
  assign line_start     = line_start_q;

endmodule

// File: tb/tb_vga_timing.sv
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic [9:0] ha, va, hb, vb;
  logic       hsa, vsa, voa, fsa, lsa;
  logic       hsb, vsb, vob, fsb, lsb;

  vga_timing dut_a (
    .clk_25(clk), .rst(rst_a),
    .horizontal_num(ha), .vertical_num(va),
    .hsync(hsa), .vsync(vsa), .video_on(voa),
    .frame_start(fsa), .line_start(lsa)
  );

  vga_timing #(
    .HVID(8), .HFP(2), .HSYNC(3), .HBP(1),
    .VVID(4), .VFP(1), .VSYNC(1), .VBP(1)
  ) dut_b (
    .clk_25(clk), .rst(rst_b),
    .horizontal_num(hb), .vertical_num(vb),
    .hsync(hsb), .vsync(vsb), .video_on(vob),
    .frame_start(fsb), .line_start(lsb)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected outputs from the raster rules: k is the number of edges since
  // reset release (k=0 is the first released edge), negative while in reset.
  // Packed as {h[9:0], v[9:0], hsync, vsync, video_on, frame_start, line_start}.
  function automatic logic [24:0] model(input int k, input int hv, input int hf,
                                        input int hs, input int hbp, input int vv,
                                        input int vf, input int vs, input int vbp);
    int ht;
    int vt;
    int h;
    int v;
    ht = hv + hf + hs + hbp;
    vt = vv + vf + vs + vbp;
    if (k < 0) return {10'(ht - 1), 10'(vt - 1), 5'b11000};
    h = k % ht;
    v = (k / ht) % vt;
    return {10'(h), 10'(v),
            !(h >= hv + hf && h < hv + hf + hs),
            !(v >= vv + vf && v < vv + vf + vs),
            (h < hv && v < vv),
            (h == 0 && v == 0),
            (h == 0)};
  endfunction

  int ka = -2;
  int kb = -2;

  always @(posedge clk) begin
    if (rst_a) ka = -1;
    else if (ka >= -1) ka++;
    if (rst_b) kb = -1;
    else if (kb >= -1) kb++;
  end

  always @(negedge clk) begin
    if (ka != -2)
      check("model_a", {7'b0, ha, va, hsa, vsa, voa, fsa, lsa},
            {7'b0, model(ka, 640, 16, 96, 48, 480, 10, 2, 33)});
    if (kb != -2)
      check("model_b", {7'b0, hb, vb, hsb, vsb, vob, fsb, lsb},
            {7'b0, model(kb, 8, 2, 3, 1, 4, 1, 1, 1)});
  end

  int   hs_low, hs_first, hs_last, hs_fall, vo_cnt, ls_cnt, guard;
  logic prev_hs;
  int   last_fs, last_ls, fs_cnt, vs_low, vs_bad, hs_bad, hsb_low, vob_cnt;
  int   hmax, vmax, wrap_line, wrap_frame;
  logic [9:0] ph, pv;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_h", ha, 799);
    check("rst_v", va, 524);
    check("rst_flags", {hsa, vsa, voa, fsa, lsa}, 5'b11000);
    rst_a = 1'b0;
    rst_b = 1'b0;

    @(negedge clk);
    check("first_h", ha, 0);
    check("first_v", va, 0);
    check("first_fs", fsa, 1);
    check("first_ls", lsa, 1);
    check("first_vo", voa, 1);
    check("first_hs", hsa, 1);
    check("first_vs", vsa, 1);
    check("first_b_hv", {hb, vb, fsb}, {10'd0, 10'd0, 1'b1});

    // One full line of the default raster.
    hs_low = 0; hs_first = -1; hs_last = -1; hs_fall = 0;
    vo_cnt = 0; ls_cnt = 0; prev_hs = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (!hsa) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(ha);
        hs_last = int'(ha);
      end
      if (prev_hs && !hsa) hs_fall++;
      prev_hs = hsa;
      vo_cnt += int'(voa);
      ls_cnt += int'(lsa);
      @(negedge clk);
    end
    check("line_hs_low", hs_low, 96);
    check("line_hs_first", hs_first, 656);
    check("line_hs_last", hs_last, 751);
    check("line_hs_pulses", hs_fall, 1);
    check("line_vo", vo_cnt, 640);
    check("line_ls_cnt", ls_cnt, 1);
    check("line_period", {ha, va, lsa}, {10'd0, 10'd1, 1'b1});

    // Mid-frame reset held for three cycles.
    guard = 0;
    while (ha != 10'd300 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_300", {ha, va}, {10'd300, 10'd1});
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_hv", {ha, va}, {10'd799, 10'd524});
      check("midrst_flags", {hsa, vsa, voa, fsa, lsa}, 5'b11000);
    end
    rst_a = 1'b0;
    @(negedge clk);
    check("midrst_release", {ha, va, fsa, lsa}, {10'd0, 10'd0, 1'b1, 1'b1});

    // Small raster: two whole frames.
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    check("b_rst_hv", {hb, vb}, {10'd13, 10'd6});
    rst_b = 1'b0;
    @(negedge clk);
    last_fs = -1; last_ls = -1; fs_cnt = 0; vs_low = 0; vs_bad = 0;
    hs_bad = 0; hsb_low = 0; vob_cnt = 0; hmax = 0; vmax = 0;
    wrap_line = 0; wrap_frame = 0; ph = '0; pv = '0;
    for (int i = 0; i < 196; i++) begin
      if (fsb) begin
        if (last_fs >= 0) check("b_frame_period", i - last_fs, 98);
        last_fs = i;
        fs_cnt++;
      end
      if (lsb) begin
        if (last_ls >= 0) check("b_line_period", i - last_ls, 14);
        last_ls = i;
      end
      if (!vsb) begin
        vs_low++;
        if (vb != 10'd5) vs_bad++;
      end
      if (!hsb) begin
        hsb_low++;
        if (hb < 10'd10 || hb > 10'd12) hs_bad++;
      end
      vob_cnt += int'(vob);
      if (int'(hb) > hmax) hmax = int'(hb);
      if (int'(vb) > vmax) vmax = int'(vb);
      if (i > 0 && ph == 10'd13 && pv == 10'd3) begin
        wrap_line++;
        check("b_wrap_line", {hb, vb}, {10'd0, 10'd4});
      end
      if (i > 0 && ph == 10'd13 && pv == 10'd6) begin
        wrap_frame++;
        check("b_wrap_frame", {hb, vb, fsb}, {10'd0, 10'd0, 1'b1});
      end
      ph = hb;
      pv = vb;
      @(negedge clk);
    end
    check("b_fs_cnt", fs_cnt, 2);
    check("b_vs_low", vs_low, 28);
    check("b_vs_line", vs_bad, 0);
    check("b_hs_low", hsb_low, 42);
    check("b_hs_range", hs_bad, 0);
    check("b_video_on", vob_cnt, 64);
    check("b_hmax", hmax, 13);
    check("b_vmax", vmax, 6);
    check("b_wrap_line_seen", wrap_line, 2);
    check("b_wrap_frame_seen", wrap_frame, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
